// File: rtl/led_status_pkg.sv
// Shared definitions for the LED status driver: channel mode encodings and
// the reset personality of each channel.
package led_status_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF    = 2'd0;
  localparam mode_t MODE_ON     = 2'd1;
  localparam mode_t MODE_BLINK  = 2'd2;
  localparam mode_t MODE_STROBE = 2'd3;

  // Channel 0 comes up as the legacy heartbeat (blink on the prescaler MSB,
  // tap resolved by the top level); every other channel comes up dark.
  localparam mode_t       CH0_RST_MODE = MODE_BLINK;
  localparam mode_t       CHN_RST_MODE = MODE_OFF;
  localparam int unsigned CHN_RST_TAP  = 0;

endpackage

// File: rtl/led_status_ctrl_channel.sv
// One LED channel: mode/tap registers, event edge detector, strobe stretcher
// and the registered LED drive.
module led_channel
  import led_status_pkg::*;
#(
  parameter int             CNT_W     = 22,
  parameter int             TAP_W     = 5,
  parameter int             STRETCH_W = 16,
  parameter mode_t          RST_MODE  = MODE_OFF,
  parameter logic [TAP_W-1:0] RST_TAP = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_load,
  input  mode_t            cfg_mode,
  input  logic [TAP_W-1:0] cfg_tap,
  input  logic [CNT_W-1:0] cnt,
  input  logic             event_in,
  output logic             led_out
);

  localparam int TAP_SPAN = 1 << TAP_W;

  mode_t                mode_reg;
  logic [TAP_W-1:0]     tap_reg;
  logic                 event_prev_reg;
  logic [STRETCH_W-1:0] stretch_reg;
  logic                 led_reg;
  logic                 led_next;
  logic                 event_rise;
  logic [TAP_SPAN-1:0]  cnt_ext;

  // Widen the prescaler so every tap code indexes a real bit.
  assign cnt_ext    = TAP_SPAN'(cnt);
  assign event_rise = event_in && !event_prev_reg;

  always_comb begin
    led_next = 1'b0;
    case (mode_reg)
      MODE_OFF:    led_next = 1'b0;
      MODE_ON:     led_next = 1'b1;
      MODE_BLINK:  led_next = cnt_ext[tap_reg];
      MODE_STROBE: led_next = (stretch_reg != '0);
      default:     led_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_reg       <= RST_MODE;
      tap_reg        <= RST_TAP;
      event_prev_reg <= 1'b0;
      stretch_reg    <= '0;
      led_reg        <= 1'b0;
    end else begin
      event_prev_reg <= event_in;
      led_reg        <= led_next;
      // A config write takes priority and swallows a coincident edge.
      if (cfg_load) begin
        mode_reg    <= cfg_mode;
        tap_reg     <= cfg_tap;
        stretch_reg <= '0;
      end else if (event_rise && (mode_reg == MODE_STROBE)) begin
        stretch_reg <= '1;
      end else if (stretch_reg != '0) begin
        stretch_reg <= stretch_reg - 1'b1;
      end
    end
  end

  assign led_out = led_reg;

endmodule

// File: rtl/led_status_ctrl.sv
// Multi-channel LED status driver: shared free-running prescaler with wrap
// tick, configuration decode and tap clamping, NUM_LEDS independent channels.
module led_status_ctrl
  import led_status_pkg::*;
#(
  parameter int NUM_LEDS  = 4,
  parameter int CNT_W     = 22,
  parameter int TAP_W     = 5,
  parameter int STRETCH_W = 16,
  parameter int SEL_W     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic [1:0]          cfg_mode,
  input  logic [TAP_W-1:0]    cfg_tap,
  input  logic [NUM_LEDS-1:0] event_in,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                tick
);

  localparam logic [TAP_W-1:0] TAP_MAX = TAP_W'(CNT_W - 1);

  logic [CNT_W-1:0]    cnt_reg;
  logic                tick_reg;
  logic [TAP_W-1:0]    tap_clamped;
  logic [NUM_LEDS-1:0] cfg_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_reg + 1'b1;
      tick_reg <= (cnt_reg == '1);
    end
  end

  assign tick        = tick_reg;
  assign tap_clamped = ({1'b0, cfg_tap} >= (TAP_W + 1)'(CNT_W)) ? TAP_MAX : cfg_tap;

  // Selects at or above NUM_LEDS match no channel, so such writes vanish.
  generate
    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
      assign cfg_hit[gi] = cfg_we && (cfg_sel == SEL_W'(gi));

      led_channel #(
        .CNT_W     (CNT_W),
        .TAP_W     (TAP_W),
        .STRETCH_W (STRETCH_W),
        .RST_MODE  ((gi == 0) ? CH0_RST_MODE : CHN_RST_MODE),
        .RST_TAP   ((gi == 0) ? TAP_MAX : TAP_W'(CHN_RST_TAP))
      ) u_chan (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_load (cfg_hit[gi]),
        .cfg_mode (cfg_mode),
        .cfg_tap  (tap_clamped),
        .cnt      (cnt_reg),
        .event_in (event_in[gi]),
        .led_out  (led_out[gi])
      );
    end
  endgenerate

endmodule
